snax_hwpe_periph_arbiter: RTL and testbench
===========================================

// Module: snax_hwpe_periph_arbiter
// PURPOSE
// - Shares one 32-bit HWPE peripheral config port between NumReq requesters (per-core SNAX CSR/accelerator controllers).
// - Round-robin arbitration; exactly one transaction in flight at any time.
// - Read data is routed back to the requester that issued the read.
// - A watchdog ends a read that never gets r_valid, so a hung accelerator cannot hold the port indefinitely.
// PARAMETERS
// - NumReq       default 2    number of requesters, >=2
// - TimeoutCycs  default 256  cycles in S_RSP with no r_valid before error completion, >=2
// - ErrData      default 32'hDEAD_BEEF  read data returned on timeout
// PORTS
// - clk_i           in   1         clock
// - rst_i           in   1         synchronous reset, active-high
// - in_req_i        in   NumReq    per-requester request valid; held with payload until in_gnt_o
// - in_add_i        in   NumReq*32 byte address
// - in_wen_i        in   NumReq    1=read, 0=write (HWPE convention)
// - in_be_i         in   NumReq*4  byte enables
// - in_data_i       in   NumReq*32 write data
// - in_id_i         in   NumReq*5  transaction id
// - in_gnt_o        out  NumReq    one-hot accept pulse, combinational
// - in_r_valid_o    out  NumReq    one-hot read-response pulse, registered
// - in_r_data_o     out  32        read data, shared, valid with in_r_valid_o
// - in_r_id_o       out  5         response id, shared
// - in_r_err_o      out  1         1 = response produced by the timeout
// - periph_req_o    out  1         HWPE periph request
// - periph_add_o / periph_wen_o / periph_be_o / periph_data_o / periph_id_o  out  32/1/4/32/5  registered payload
// - periph_gnt_i    in   1         HWPE grant
// - periph_r_valid_i / periph_r_data_i / periph_r_id_i  in  1/32/5  HWPE read response
// BEHAVIOUR
// - Reset (rst_i=1 at a clock edge): state=S_IDLE; every periph_* and in_r_* output = 0; in_gnt_o = 0; rr_ptr = NumReq-1.
// - Reset mid-operation drops the in-flight transaction. No response is produced for it.
// - Arbitration, S_IDLE only: winner = first asserted in_req_i scanning upward from rr_ptr+1, wrapping modulo NumReq.
//   - in_gnt_o[winner]=1 in that same cycle.
//   - At the clock edge: payload is latched onto periph_*, periph_req_o<=1, rr_ptr<=winner, state->S_ISS.
//   - in_gnt_o is 0 in every other state.
// - S_ISS: periph_req_o and payload stay stable until periph_gnt_i.
//   - On gnt with a write: periph_* <= 0, go to S_IDLE.
//   - On gnt with a read: periph_* <= 0, owner index is kept, counter <= 0, go to S_RSP.
// - S_RSP: counter increments each cycle.
//   - On periph_r_valid_i: next cycle in_r_valid_o[owner]=1 for 1 cycle, in_r_data_o/in_r_id_o take periph values, in_r_err_o=0; go to S_IDLE.
//   - Timeout, when counter==TimeoutCycs-1 and no r_valid: in_r_valid_o[owner]=1, in_r_data_o=ErrData, in_r_id_o=the latched id, in_r_err_o=1; go to S_IDLE.
//   - If r_valid and the timeout happen in the same cycle, r_valid wins and err=0.
//   - r_valid arriving in S_IDLE or S_ISS (stray, or late after a timeout) is ignored.
// - in_r_* are 0 in every cycle without a response pulse.
// - Latency:
//   - request to periph_req_o: 1 cycle.
//   - write with immediate gnt: back in S_IDLE 2 cycles after in_gnt_o.
//   - read: response 1 cycle after periph_r_valid_i.
// - The earliest next grant is in the cycle S_IDLE is re-entered. Rate is at most 1 transaction per 2 cycles.
// - A request withdrawn before its grant is legal; arbitration recomputes every cycle.
// - Width rules:
//   - Owner index: $clog2(NumReq) bits.
//   - Counter: $clog2(TimeoutCycs) bits, no wrap because it exits at the terminal count.
// STRUCTURE
// - Package snax_hwpe_arb_pkg contains:
//   - arb_state_e {S_IDLE,S_ISS,S_RSP}
//   - periph_req_t {id[4:0],add[31:0],wen,be[3:0],data[31:0]}
//   - periph_rsp_t {r_id[4:0],r_data[31:0],err}
// - Sub-module snax_rr_picker (combinational):
//   - Inputs: req vector, rr_ptr.
//   - Outputs: one-hot grant, binary index, any_valid.
// - Top level: FSM, payload register, owner register, watchdog counter, response register.
// TESTING
// - Single write:
//   - Stimulus: req0 add=0x4C data=0x100 wen=0; periph_gnt_i high.
//   - Response: gnt_o=01 in cycle 0; periph_req_o=1 with those values in cycle 1; periph_req_o=0 in cycle 2; no in_r_valid_o pulse.
// - Read routing:
//   - Stimulus: req1 read add=0x08 id=3; periph_r_valid_i with data=0xCAFE, 2 cycles after gnt.
//   - Response: in_r_valid_o=10, in_r_data_o=0xCAFE, in_r_id_o=3, in_r_err_o=0.
// - Round-robin:
//   - Stimulus: req0 and req1 held continuously out of reset, 4 writes each.
//   - Response: grant order 0,1,0,1,...; no requester waits more than one transaction.
// - Grant stall:
//   - Stimulus: periph_gnt_i held low for 5 cycles.
//   - Response: payload stable on every cycle; no in_gnt_o while stalled.
// - Timeout:
//   - Stimulus: TimeoutCycs=8, read from req0 with no r_valid; then a late r_valid.
//   - Response: in_r_valid_o=01, in_r_err_o=1, in_r_data_o=0xDEADBEEF 8 cycles after entering S_RSP; the late r_valid is ignored.
// - Reset:
//   - Stimulus: rst_i pulsed while in S_RSP.
//   - Response: all outputs 0 next cycle; the next grant goes to req0.

Source files
------------

// File: rtl/snax_hwpe_arb_pkg.sv
// Shared types for the SNAX HWPE peripheral-port arbiter: FSM states and
// the request/response payload records carried through the arbiter.
package snax_hwpe_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISS,
    S_RSP
  } arb_state_e;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } periph_req_t;

  typedef struct packed {
    logic [4:0]  r_id;
    logic [31:0] r_data;
    logic        err;
  } periph_rsp_t;

endpackage

// File: rtl/snax_rr_picker.sv
// Combinational round-robin picker: first asserted request strictly after
// rr_ptr_i, wrapping, so the last winner has the lowest priority.
module snax_rr_picker #(
  parameter int NumReq = 2,
  localparam int IdxW = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   rr_ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  int cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int i = 1; i <= NumReq; i++) begin
      cand = (int'(rr_ptr_i) + i) % NumReq;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/snax_hwpe_periph_arbiter.sv
// Round-robin sharing of one HWPE peripheral config port between NumReq
// requesters, one transaction in flight, with a read-response watchdog.
module snax_hwpe_periph_arbiter
  import snax_hwpe_arb_pkg::*;
#(
  parameter int          NumReq      = 2,
  parameter int          TimeoutCycs = 256,
  parameter logic [31:0] ErrData     = 32'hDEAD_BEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumReq-1:0]    in_req_i,
  input  logic [NumReq*32-1:0] in_add_i,
  input  logic [NumReq-1:0]    in_wen_i,
  input  logic [NumReq*4-1:0]  in_be_i,
  input  logic [NumReq*32-1:0] in_data_i,
  input  logic [NumReq*5-1:0]  in_id_i,
  output logic [NumReq-1:0]    in_gnt_o,
  output logic [NumReq-1:0]    in_r_valid_o,
  output logic [31:0]          in_r_data_o,
  output logic [4:0]           in_r_id_o,
  output logic                 in_r_err_o,
  output logic                 periph_req_o,
  output logic [31:0]          periph_add_o,
  output logic                 periph_wen_o,
  output logic [3:0]           periph_be_o,
  output logic [31:0]          periph_data_o,
  output logic [4:0]           periph_id_o,
  input  logic                 periph_gnt_i,
  input  logic                 periph_r_valid_i,
  input  logic [31:0]          periph_r_data_i,
  input  logic [4:0]           periph_r_id_i
);

  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(TimeoutCycs);

  arb_state_e          state;
  logic [IdxW-1:0]     rr_ptr;
  logic [IdxW-1:0]     owner;
  logic [4:0]          rd_id;
  logic [CntW-1:0]     cnt;
  periph_req_t         req_q;
  logic                periph_req_q;
  periph_rsp_t         rsp_q;
  logic [NumReq-1:0]   r_valid_q;

  logic [NumReq-1:0]   pick_gnt;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_any;
  periph_req_t         sel;

  snax_rr_picker #(.NumReq(NumReq)) i_picker (
    .req_i    (in_req_i),
    .rr_ptr_i (rr_ptr),
    .gnt_o    (pick_gnt),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    sel      = '0;
    sel.id   = in_id_i[int'(pick_idx)*5 +: 5];
    sel.add  = in_add_i[int'(pick_idx)*32 +: 32];
    sel.wen  = in_wen_i[pick_idx];
    sel.be   = in_be_i[int'(pick_idx)*4 +: 4];
    sel.data = in_data_i[int'(pick_idx)*32 +: 32];
  end

  assign in_gnt_o = (state == S_IDLE && !rst_i) ? pick_gnt : '0;

  // Response outputs are single-cycle pulses; they default to zero each cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      rr_ptr       <= IdxW'(NumReq - 1);
      owner        <= '0;
      rd_id        <= '0;
      cnt          <= '0;
      req_q        <= '0;
      periph_req_q <= 1'b0;
      rsp_q        <= '0;
      r_valid_q    <= '0;
    end else begin
      rsp_q     <= '0;
      r_valid_q <= '0;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            req_q        <= sel;
            periph_req_q <= 1'b1;
            rr_ptr       <= pick_idx;
            owner        <= pick_idx;
            rd_id        <= sel.id;
            state        <= S_ISS;
          end
        end
        S_ISS: begin
          if (periph_gnt_i) begin
            req_q        <= '0;
            periph_req_q <= 1'b0;
            cnt          <= '0;
            state        <= req_q.wen ? S_RSP : S_IDLE;
          end
        end
        S_RSP: begin
          cnt <= cnt + CntW'(1);
          if (periph_r_valid_i) begin
            r_valid_q[owner] <= 1'b1;
            rsp_q            <= '{r_id: periph_r_id_i, r_data: periph_r_data_i, err: 1'b0};
            state            <= S_IDLE;
          end else if (cnt == CntW'(TimeoutCycs - 1)) begin
            r_valid_q[owner] <= 1'b1;
            rsp_q            <= '{r_id: rd_id, r_data: ErrData, err: 1'b1};
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign periph_req_o  = periph_req_q;
  assign periph_add_o  = req_q.add;
  assign periph_wen_o  = req_q.wen;
  assign periph_be_o   = req_q.be;
  assign periph_data_o = req_q.data;
  assign periph_id_o   = req_q.id;

  assign in_r_valid_o  = r_valid_q;
  assign in_r_data_o   = rsp_q.r_data;
  assign in_r_id_o     = rsp_q.r_id;
  assign in_r_err_o    = rsp_q.err;

endmodule

// File: tb/tb_snax_hwpe_periph_arbiter.sv
// Directed bench for snax_hwpe_periph_arbiter with two requesters and a short
// watchdog so the timeout path is reachable.
module tb_snax_hwpe_periph_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_req;
  logic [63:0] in_add;
  logic [1:0]  in_wen;
  logic [7:0]  in_be;
  logic [63:0] in_data;
  logic [9:0]  in_id;
  logic [1:0]  in_gnt;
  logic [1:0]  in_r_valid;
  logic [31:0] in_r_data;
  logic [4:0]  in_r_id;
  logic        in_r_err;
  logic        periph_req;
  logic [31:0] periph_add;
  logic        periph_wen;
  logic [3:0]  periph_be;
  logic [31:0] periph_data;
  logic [4:0]  periph_id;
  logic        periph_gnt;
  logic        periph_r_valid;
  logic [31:0] periph_r_data;
  logic [4:0]  periph_r_id;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  snax_hwpe_periph_arbiter #(
    .NumReq      (2),
    .TimeoutCycs (8),
    .ErrData     (32'hDEAD_BEEF)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .in_req_i         (in_req),
    .in_add_i         (in_add),
    .in_wen_i         (in_wen),
    .in_be_i          (in_be),
    .in_data_i        (in_data),
    .in_id_i          (in_id),
    .in_gnt_o         (in_gnt),
    .in_r_valid_o     (in_r_valid),
    .in_r_data_o      (in_r_data),
    .in_r_id_o        (in_r_id),
    .in_r_err_o       (in_r_err),
    .periph_req_o     (periph_req),
    .periph_add_o     (periph_add),
    .periph_wen_o     (periph_wen),
    .periph_be_o      (periph_be),
    .periph_data_o    (periph_data),
    .periph_id_o      (periph_id),
    .periph_gnt_i     (periph_gnt),
    .periph_r_valid_i (periph_r_valid),
    .periph_r_data_i  (periph_r_data),
    .periph_r_id_i    (periph_r_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b1;
    in_req = '0; in_add = '0; in_wen = '0; in_be = '0; in_data = '0; in_id = '0;
    periph_gnt = 1'b0; periph_r_valid = 1'b0; periph_r_data = '0; periph_r_id = '0;
    step();
    step();
    chk("rst_periph_req", {31'd0, periph_req}, 32'd0);
    chk("rst_r_valid", {30'd0, in_r_valid}, 32'd0);
    chk("rst_gnt", {30'd0, in_gnt}, 32'd0);
    rst = 1'b0;

    // Single write from requester 0
    in_req = 2'b01; in_add[31:0] = 32'h4C; in_data[31:0] = 32'h100;
    in_wen = 2'b00; in_be = 8'hFF; periph_gnt = 1'b1;
    #1 chk("wr_gnt", {30'd0, in_gnt}, 32'h1);
    step();
    in_req = 2'b00;
    #1;
    chk("wr_periph_req", {31'd0, periph_req}, 32'd1);
    chk("wr_add", periph_add, 32'h4C);
    chk("wr_data", periph_data, 32'h100);
    chk("wr_wen", {31'd0, periph_wen}, 32'd0);
    chk("wr_be", {28'd0, periph_be}, 32'hF);
    chk("wr_no_gnt_iss", {30'd0, in_gnt}, 32'd0);
    step();
    chk("wr_periph_req_off", {31'd0, periph_req}, 32'd0);
    chk("wr_no_rvalid", {30'd0, in_r_valid}, 32'd0);
    step();
    chk("wr_no_rvalid2", {30'd0, in_r_valid}, 32'd0);

    // Read from requester 1, response routed back to it
    in_req = 2'b10; in_add[63:32] = 32'h08; in_wen = 2'b10; in_id[9:5] = 5'd3;
    #1 chk("rd_gnt", {30'd0, in_gnt}, 32'h2);
    step();
    in_req = 2'b00;
    #1;
    chk("rd_add", periph_add, 32'h08);
    chk("rd_wen", {31'd0, periph_wen}, 32'd1);
    chk("rd_id", {27'd0, periph_id}, 32'd3);
    step();
    periph_r_valid = 1'b1; periph_r_data = 32'hCAFE; periph_r_id = 5'd3;
    step();
    periph_r_valid = 1'b0;
    #1;
    chk("rd_rvalid", {30'd0, in_r_valid}, 32'h2);
    chk("rd_rdata", in_r_data, 32'hCAFE);
    chk("rd_rid", {27'd0, in_r_id}, 32'd3);
    chk("rd_rerr", {31'd0, in_r_err}, 32'd0);
    step();
    chk("rd_rvalid_off", {30'd0, in_r_valid}, 32'd0);
    chk("rd_rdata_off", in_r_data, 32'd0);

    // Round-robin: both held from reset, 4 writes each
    rst = 1'b1;
    in_req = 2'b11; in_wen = 2'b00;
    in_data = {32'h222, 32'h111}; in_add = {32'h24, 32'h14};
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("rr_gnt_%0d", k), {30'd0, in_gnt}, (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
      chk($sformatf("rr_data_%0d", k), periph_data, (k % 2 == 0) ? 32'h111 : 32'h222);
      chk($sformatf("rr_iss_gnt_%0d", k), {30'd0, in_gnt}, 32'd0);
      step();
    end
    in_req = 2'b00;
    #1;

    // Grant stall: payload stable, no grants while periph_gnt is low
    periph_gnt = 1'b0;
    in_req = 2'b01; in_add[31:0] = 32'h10; in_data[31:0] = 32'h55AA;
    #1 chk("st_gnt", {30'd0, in_gnt}, 32'h1);
    step();
    in_req = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("st_req_%0d", k), {31'd0, periph_req}, 32'd1);
      chk($sformatf("st_add_%0d", k), periph_add, 32'h10);
      chk($sformatf("st_data_%0d", k), periph_data, 32'h55AA);
      chk($sformatf("st_nognt_%0d", k), {30'd0, in_gnt}, 32'd0);
      step();
    end
    periph_gnt = 1'b1;
    #1 chk("st_req_last", {31'd0, periph_req}, 32'd1);
    step();
    chk("st_next_gnt", {30'd0, in_gnt}, 32'h2);
    step();
    in_req = 2'b00;
    chk("st_next_data", periph_data, 32'h222);
    step();

    // Timeout: read from requester 0 never answered, then a late r_valid
    in_req = 2'b01; in_wen = 2'b01; in_add[31:0] = 32'h20; in_id[4:0] = 5'd7;
    #1 chk("to_gnt", {30'd0, in_gnt}, 32'h1);
    step();
    in_req = 2'b00;
    step();
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("to_wait_%0d", k), {30'd0, in_r_valid}, 32'd0);
    end
    step();
    chk("to_rvalid", {30'd0, in_r_valid}, 32'h1);
    chk("to_err", {31'd0, in_r_err}, 32'd1);
    chk("to_data", in_r_data, 32'hDEADBEEF);
    chk("to_id", {27'd0, in_r_id}, 32'd7);
    periph_r_valid = 1'b1; periph_r_data = 32'h1234; periph_r_id = 5'd7;
    step();
    periph_r_valid = 1'b0;
    chk("late_rvalid", {30'd0, in_r_valid}, 32'd0);
    chk("late_err", {31'd0, in_r_err}, 32'd0);
    step();
    chk("late_rvalid2", {30'd0, in_r_valid}, 32'd0);

    // Reset while in S_RSP
    in_req = 2'b01; in_wen = 2'b01; in_add[31:0] = 32'h30;
    #1 chk("rs_gnt", {30'd0, in_gnt}, 32'h1);
    step();
    in_req = 2'b00;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rs_periph_req", {31'd0, periph_req}, 32'd0);
    chk("rs_periph_add", periph_add, 32'd0);
    chk("rs_r_valid", {30'd0, in_r_valid}, 32'd0);
    chk("rs_r_err", {31'd0, in_r_err}, 32'd0);
    chk("rs_gnt_idle", {30'd0, in_gnt}, 32'd0);
    in_req = 2'b11; in_wen = 2'b00;
    #1 chk("rs_next_gnt", {30'd0, in_gnt}, 32'h1);
    step();
    in_req = 2'b00;
    chk("rs_next_add", periph_add, 32'h30);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
